button_conditioner: RTL and testbench

Input-side front end for the dice-game board.
- Takes raw push-button levels (start/roll, Rb/stop, Reset key) from board pins, which are asynchronous, bouncy and possibly active-low.
- Delivers clean, clk-synchronous signals per button: debounced level, single-cycle press pulse, single-cycle release pulse and a press-toggle state.
- Game logic consumes these on clk alone instead of clocking on raw button edges.

---
 rtl/dice_pkg.sv | 14 +
 rtl/debounce_channel.sv | 75 +++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared constants for the dice-game board: clock rate, debounce timing and button indices.
package dice_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int NUM_BTN_DEFAULT         = 3;

    localparam int BTN_ROLL  = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_RESET = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button: synchronizer, debounce counter, stable level and registered press/release/toggle.
// Clean pin edge reaches o_level/o_press after SYNC_STAGES + DEBOUNCE_CYCLES edges.
module debounce_channel
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_toggle
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   r_release;
    logic                   r_toggle;

    logic w_pressed;
    logic w_differs;
    logic w_accept;

    // Polarity is normalized only after the last stage so the sync chain stays a plain shift register.
    assign w_pressed = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign w_differs = (w_pressed != r_stable);
    assign w_accept  = w_differs && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_press   <= w_accept & w_pressed;
            r_release <= w_accept & ~w_pressed;
            if (w_accept) begin
                r_stable <= w_pressed;
                r_cnt    <= '0;
                if (w_pressed) begin
                    r_toggle <= ~r_toggle;
                end
            end else if (w_differs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_toggle  = r_toggle;

endmodule

// File: rtl/button_conditioner.sv
// Bundles NUM_BTN independent debounce channels into vectors for the game logic.
// Per-channel latency SYNC_STAGES + DEBOUNCE_CYCLES edges from a clean pin edge.
module button_conditioner
    import dice_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_toggle
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .Reset     (Reset),
            .i_btn_raw (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_toggle  (btn_toggle[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed test-plan scenarios plus random bouncy stimulus,
// all checked each cycle against a window-based behavioural model.
module tb_button_conditioner;

    localparam int NB  = 3;
    localparam int DEB = 8;
    localparam int SYN = 2;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [NB-1:0] btn_raw = '1;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle;

    int n_cmp = 0;
    int n_mis = 0;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the value seen by the debouncer is the pin sampled SYN edges earlier, inverted;
    // a level is accepted when the last DEB seen values all differ from the current stable level.
    bit            pins[NB][$];
    bit            hist[NB][$];
    logic [NB-1:0] m_level, m_press, m_release, m_toggle;
    bit            model_valid = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (Reset) begin
                pins[c].delete();
                for (int k = 0; k < SYN; k++) pins[c].push_back(1'b1);
                hist[c].delete();
                m_level[c]   = 1'b0;
                m_press[c]   = 1'b0;
                m_release[c] = 1'b0;
                m_toggle[c]  = 1'b0;
            end else if (model_valid) begin
                bit seen;
                bit all_diff;
                seen = ~pins[c].pop_front();
                pins[c].push_back(btn_raw[c]);
                hist[c].push_back(seen);
                if (hist[c].size() > DEB) void'(hist[c].pop_front());
                m_press[c]   = 1'b0;
                m_release[c] = 1'b0;
                all_diff = (hist[c].size() == DEB);
                foreach (hist[c][k]) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c]   = seen;
                    m_press[c]   = seen;
                    m_release[c] = ~seen;
                    if (seen) m_toggle[c] = ~m_toggle[c];
                end
            end
        end
        if (Reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_level",   32'(btn_level),   32'(m_level));
            check("model_press",   32'(btn_press),   32'(m_press));
            check("model_release", 32'(btn_release), 32'(m_release));
            check("model_toggle",  32'(btn_toggle),  32'(m_toggle));
        end
    end

    task automatic hold(input int ch, input logic val, input int n);
        btn_raw[ch] = val;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("bounce_no_press", 32'(btn_press[ch]), 32'd0);
            check("bounce_level",    32'(btn_level[ch]), 32'd0);
        end
    endtask

    // Counts negedges until btn_press[ch] rises; expects exactly exp_edges.
    task automatic wait_press(input string nm, input int ch, input int exp_edges);
        int found = 0;
        for (int i = 1; i <= 40 && found == 0; i++) begin
            @(negedge clk);
            if (btn_press[ch]) found = i;
        end
        check(nm, 32'(found), 32'(exp_edges));
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        int n_p, n_r;
        int timer[NB];
        logic [NB-1:0] tog_at_press[$];

        // Reset held 3 cycles with all pins inactive.
        Reset   = 1'b1;
        btn_raw = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_level",   32'(btn_level),   32'd0);
            check("rst_press",   32'(btn_press),   32'd0);
            check("rst_release", 32'(btn_release), 32'd0);
            check("rst_toggle",  32'(btn_toggle),  32'd0);
        end
        Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_no_pulse", 32'(btn_press | btn_release), 32'd0);
        end

        // Clean press on channel 0: level and press on the 10th edge.
        btn_raw[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("ch0_level_early", 32'(btn_level[0]), 32'd0);
        end
        @(negedge clk);
        check("ch0_level_edge10", 32'(btn_level[0]), 32'd1);
        check("ch0_press_edge10", 32'(btn_press[0]), 32'd1);
        check("ch0_toggle",       32'(btn_toggle[0]), 32'd1);
        check("ch12_unchanged",   32'(btn_level[2:1]), 32'd0);
        @(negedge clk);
        check("ch0_press_edge11", 32'(btn_press[0]), 32'd0);

        // Bounce on channel 1 never accepted, then a clean hold.
        hold(1, 1'b0, 3);
        hold(1, 1'b1, 2);
        hold(1, 1'b0, 5);
        hold(1, 1'b1, 5);
        btn_raw[1] = 1'b0;
        wait_press("ch1_press_after_bounce", 1, 10);
        btn_raw = 3'b111;
        repeat (20) @(negedge clk);

        // Press/release twice on channel 0 from a fresh reset.
        do_reset(2);
        n_p = 0;
        n_r = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int ph = 0; ph < 2; ph++) begin
                btn_raw[0] = (ph == 0) ? 1'b0 : 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (btn_press[0]) begin
                        n_p++;
                        tog_at_press.push_back(btn_toggle);
                    end
                    if (btn_release[0]) n_r++;
                end
            end
        end
        check("ch0_press_count",   32'(n_p), 32'd2);
        check("ch0_release_count", 32'(n_r), 32'd2);
        check("ch0_toggle_seq_n",  32'(tog_at_press.size()), 32'd2);
        if (tog_at_press.size() == 2) begin
            check("ch0_toggle_1st", 32'(tog_at_press[0][0]), 32'd1);
            check("ch0_toggle_2nd", 32'(tog_at_press[1][0]), 32'd0);
        end
        check("ch0_toggle_final", 32'(btn_toggle[0]), 32'd0);

        // Reset mid-count on channel 2 discards the count; fresh press afterwards.
        btn_raw[2] = 1'b0;
        repeat (7) @(negedge clk);
        check("ch2_level_midcount", 32'(btn_level[2]), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        check("ch2_no_pulse_on_reset", 32'(btn_press | btn_release), 32'd0);
        Reset = 1'b0;
        wait_press("ch2_press_after_reset", 2, 10);

        // All three pressed on the same edge.
        btn_raw = 3'b111;
        repeat (30) @(negedge clk);
        btn_raw = 3'b000;
        repeat (9) @(negedge clk);
        check("all_press_before", 32'(btn_press), 32'd0);
        @(negedge clk);
        check("all_press_same_cycle", 32'(btn_press), 32'b111);
        @(negedge clk);
        check("all_press_next_cycle", 32'(btn_press), 32'b000);

        // Random bouncy and clean segments with occasional reset.
        for (int c = 0; c < NB; c++) timer[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            Reset = ($urandom_range(0, 599) == 0);
            for (int c = 0; c < NB; c++) begin
                if (timer[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    timer[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(9, 30)
                                                          : $urandom_range(1, 9);
                end else begin
                    timer[c]--;
                end
            end
            @(negedge clk);
        end
        Reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
